// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared constants for the intersection sequencer: 3-bit state
//               encodings, one-hot lamp codes {red,yellow,green} and the
//               default phase durations (in enable ticks).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // FSM state encodings; 3'd6 and 3'd7 are unreachable.
    localparam logic [2:0] c_ST_ALL_RED_A   = 3'd0;
    localparam logic [2:0] c_ST_MAIN_GREEN  = 3'd1;
    localparam logic [2:0] c_ST_MAIN_YELLOW = 3'd2;
    localparam logic [2:0] c_ST_ALL_RED_B   = 3'd3;
    localparam logic [2:0] c_ST_SIDE_GREEN  = 3'd4;
    localparam logic [2:0] c_ST_SIDE_YELLOW = 3'd5;

    // Lamp codes, bit order {red,yellow,green}
    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    // Default durations in enable ticks
    localparam int c_DEF_GREEN_MAIN = 20;
    localparam int c_DEF_GREEN_SIDE = 10;
    localparam int c_DEF_YELLOW     = 3;
    localparam int c_DEF_ALL_RED    = 1;
    localparam int c_DEF_CNT_W      = 8;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Tick counter for one phase. Clears synchronously, increments
//               only on enable ticks, saturates at i_last (= DUR-1) and flags
//               o_done on the tick that completes the phase.
// Ports       : clk, rst_n (async active-low), i_clear, i_tick,
//               i_last[CNT_W-1:0], o_done
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count < i_last)) begin
            // Saturation lets a held phase (main green, no request) park at
            // DUR-1 so the next tick with a request exits immediately.
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = i_tick && (r_count == i_last);

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_fsm
// Description : Intersection sequencer timed by a one-cycle enable tick.
//               Cycles main/side phases with yellow and all-red clearance;
//               the side phase is granted only when a request is pending.
// Ports       : clk, reset (async active-low), enable (time-base tick),
//               side_sensor, ped_button -> main_light[2:0], side_light[2:0],
//               walk, state_out[2:0]
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_MAIN = c_DEF_GREEN_MAIN,
    parameter int GREEN_SIDE = c_DEF_GREEN_SIDE,
    parameter int YELLOW     = c_DEF_YELLOW,
    parameter int ALL_RED    = c_DEF_ALL_RED,
    parameter int CNT_W      = c_DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       side_sensor,
    input  logic       ped_button,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state_out
);

    localparam logic [CNT_W-1:0] c_LAST_GM = CNT_W'(GREEN_MAIN - 1);
    localparam logic [CNT_W-1:0] c_LAST_GS = CNT_W'(GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] c_LAST_YL = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] c_LAST_AR = CNT_W'(ALL_RED - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_req;
    logic             r_ped;
    logic             r_walk_en;
    logic [CNT_W-1:0] w_last;
    logic             w_done;
    logic             w_state_chg;
    logic             w_enter_sg;

    // Terminal count for the phase currently being timed
    always_comb begin
        w_last = c_LAST_AR;
        case (r_state)
            c_ST_MAIN_GREEN:  w_last = c_LAST_GM;
            c_ST_MAIN_YELLOW: w_last = c_LAST_YL;
            c_ST_SIDE_GREEN:  w_last = c_LAST_GS;
            c_ST_SIDE_YELLOW: w_last = c_LAST_YL;
            default:          w_last = c_LAST_AR;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (w_state_chg),
        .i_tick  (enable),
        .i_last  (w_last),
        .o_done  (w_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_ALL_RED_A:   if (w_done)          w_next = c_ST_MAIN_GREEN;
            c_ST_MAIN_GREEN:  if (w_done && r_req) w_next = c_ST_MAIN_YELLOW;
            c_ST_MAIN_YELLOW: if (w_done)          w_next = c_ST_ALL_RED_B;
            c_ST_ALL_RED_B:   if (w_done)          w_next = c_ST_SIDE_GREEN;
            c_ST_SIDE_GREEN:  if (w_done)          w_next = c_ST_SIDE_YELLOW;
            c_ST_SIDE_YELLOW: if (w_done)          w_next = c_ST_ALL_RED_A;
            default:                               w_next = c_ST_ALL_RED_A;
        endcase
    end

    assign w_state_chg = (w_next != r_state);
    assign w_enter_sg  = w_state_chg && (w_next == c_ST_SIDE_GREEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_ALL_RED_A;
            r_req     <= 1'b0;
            r_ped     <= 1'b0;
            r_walk_en <= 1'b0;
        end else begin
            r_state <= w_next;
            // A request arriving on the entry edge survives (set wins) so
            // it is served in the following cycle.
            r_req   <= side_sensor | ped_button | (r_req & ~w_enter_sg);
            r_ped   <= ped_button | (r_ped & ~w_enter_sg);
            if (w_enter_sg) begin
                r_walk_en <= r_ped;
            end
        end
    end

    // Moore lamp decode from registered state only
    always_comb begin
        main_light = c_RED;
        side_light = c_RED;
        case (r_state)
            c_ST_MAIN_GREEN:  main_light = c_GRN;
            c_ST_MAIN_YELLOW: main_light = c_YEL;
            c_ST_SIDE_GREEN:  side_light = c_GRN;
            c_ST_SIDE_YELLOW: side_light = c_YEL;
            default: begin
                main_light = c_RED;
                side_light = c_RED;
            end
        endcase
    end

    assign walk      = r_walk_en && (r_state == c_ST_SIDE_GREEN);
    assign state_out = r_state;

endmodule : traffic_light_fsm
`default_nettype wire
